// File: rtl/shop_pkg.sv
// shop_pkg: shared types and constants for the shop command controller.
// Holds the FSM state enum, the pending-command enum, the ASCII command keys,
// the ASCII status words and the permission bit positions.
// Keys and status words are right-aligned and zero-padded ASCII.
// Users of these constants resize them to their own token widths.
package shop_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_USRNAME,
    ST_PASSWRD,
    ST_PERMS,
    ST_ITMNAME,
    ST_ITMSTCK
  } state_t;

  // Command accepted in ST_CMD. Remembered while its operands arrive.
  typedef enum logic [2:0] {
    OP_LOGIN,
    OP_ADDUSR,
    OP_DELUSR,
    OP_ADDITEM,
    OP_DELITEM,
    OP_BUY
  } op_t;

  localparam int PERM_SELLER = 0;
  localparam int PERM_ADMIN  = 1;

  // Command keys. The longest key, "AddItem", is 7 characters.
  localparam int KEY_W = 56;
  localparam logic [KEY_W-1:0] KEY_LOGIN   = KEY_W'("Login");
  localparam logic [KEY_W-1:0] KEY_LOGOUT  = KEY_W'("Logout");
  localparam logic [KEY_W-1:0] KEY_ADDUSR  = KEY_W'("AddUsr");
  localparam logic [KEY_W-1:0] KEY_DELUSR  = KEY_W'("DelUsr");
  localparam logic [KEY_W-1:0] KEY_ADDITEM = KEY_W'("AddItem");
  localparam logic [KEY_W-1:0] KEY_DELITEM = KEY_W'("DelItem");
  localparam logic [KEY_W-1:0] KEY_BUY     = KEY_W'("Buy");

  // Status words. The longest status word is 9 characters.
  localparam int STAT_W = 72;
  localparam logic [STAT_W-1:0] MSG_CMD       = STAT_W'("Cmd?");
  localparam logic [STAT_W-1:0] MSG_INVALCMD  = STAT_W'("InvalCmd");
  localparam logic [STAT_W-1:0] MSG_INVALPERM = STAT_W'("InvalPerm");
  localparam logic [STAT_W-1:0] MSG_LOGGEDOUT = STAT_W'("LoggedOut");
  localparam logic [STAT_W-1:0] MSG_USRNAME   = STAT_W'("Usrname?");
  localparam logic [STAT_W-1:0] MSG_ITMNAME   = STAT_W'("ItmName?");
  localparam logic [STAT_W-1:0] MSG_PASSWRD   = STAT_W'("Passwrd?");
  localparam logic [STAT_W-1:0] MSG_USRUNKNWN = STAT_W'("UsrUnknwn");
  localparam logic [STAT_W-1:0] MSG_USRTAKEN  = STAT_W'("UsrTaken");
  localparam logic [STAT_W-1:0] MSG_USRSFULL  = STAT_W'("UsrsFull");
  localparam logic [STAT_W-1:0] MSG_NODELADMN = STAT_W'("NoDelAdmn");
  localparam logic [STAT_W-1:0] MSG_USRDELETD = STAT_W'("UsrDeletd");
  localparam logic [STAT_W-1:0] MSG_LOGGEDIN  = STAT_W'("LoggedIn");
  localparam logic [STAT_W-1:0] MSG_BADPASS   = STAT_W'("BadPass");
  localparam logic [STAT_W-1:0] MSG_PERMS     = STAT_W'("Perms?");
  localparam logic [STAT_W-1:0] MSG_USRADDED  = STAT_W'("UsrAdded");
  localparam logic [STAT_W-1:0] MSG_ITMEXISTS = STAT_W'("ItmExists");
  localparam logic [STAT_W-1:0] MSG_ITMSFULL  = STAT_W'("ItmsFull");
  localparam logic [STAT_W-1:0] MSG_STOCK     = STAT_W'("Stock?");
  localparam logic [STAT_W-1:0] MSG_ITMUNKNWN = STAT_W'("ItmUnknwn");
  localparam logic [STAT_W-1:0] MSG_NTYOURITM = STAT_W'("NtYourItm");
  localparam logic [STAT_W-1:0] MSG_ITMDELETD = STAT_W'("ItmDeletd");
  localparam logic [STAT_W-1:0] MSG_NOSTOCK   = STAT_W'("NoStock");
  localparam logic [STAT_W-1:0] MSG_ITMBOUGHT = STAT_W'("ItmBought");
  localparam logic [STAT_W-1:0] MSG_ITMADDED  = STAT_W'("ItmAdded");

endpackage

// File: rtl/shop_if.sv
// shop_if: token/response bundle between the token source and shop_ctrl.
// Signals:
//   i_rdy  - token strobe
//   i_a    - ASCII token, right-aligned and zero-padded
//   i_u    - numeric token
//   o_a    - registered ASCII status word
//   o_vld  - one-cycle pulse on each o_a update
// The master modport drives tokens. The slave modport is the controller.
interface shop_if #(
  parameter int IA_CHARS = 7,
  parameter int OA_CHARS = 9,
  parameter int U_BITS   = 4
);
  logic                    i_rdy;
  logic [8*IA_CHARS-1:0]   i_a;
  logic [U_BITS-1:0]       i_u;
  logic [8*OA_CHARS-1:0]   o_a;
  logic                    o_vld;

  modport master (output i_rdy, i_a, i_u, input o_a, o_vld);
  modport slave  (input i_rdy, i_a, i_u, output o_a, o_vld);
endinterface

// File: rtl/shop_cam_lookup.sv
// shop_cam_lookup: combinational content-addressed lookup over a small table.
// Ports:
//   key      - value searched for
//   keys     - stored table entries
//   used     - per-entry occupancy; free entries never hit
//   hit      - some used entry equals key
//   hit_idx  - index of the lowest matching entry
//   free_idx - index of the lowest free entry
//   full     - no free entry
module shop_cam_lookup #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 56,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] keys [DEPTH],
  input  logic [DEPTH-1:0] used,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [IDX_W-1:0] free_idx,
  output logic             full
);

  logic free_found;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && used[i] && (keys[i] == key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!free_found && !used[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign full = &used;

endmodule

// File: rtl/shop_ctrl.sv
// shop_ctrl: token-driven command controller for the shop database.
// The controller keeps a user table and an item table. It answers every
// strobed token with a status word one cycle later.
// Ports:
//   i_clk   - clock
//   i_reset - synchronous, active-high reset
//   bus     - shop_if slave: i_rdy/i_a/i_u tokens in, o_a/o_vld out
module shop_ctrl
  import shop_pkg::*;
#(
  parameter int MAX_USERS           = 5,
  parameter int MAX_ITEMS           = 8,
  parameter int I_A_NUM_ASCII_CHARS = 7,
  parameter int O_A_NUM_ASCII_CHARS = 9,
  parameter int I_U_NUM_BITS        = 4,
  parameter logic [8*I_A_NUM_ASCII_CHARS-1:0] ADMIN_USERNAME =
    {{(8*I_A_NUM_ASCII_CHARS-24){1'b0}}, "Adm"},
  parameter logic [I_U_NUM_BITS-1:0] ADMIN_PASSWORD = '0
) (
  input logic   i_clk,
  input logic   i_reset,
  shop_if.slave bus
);

  localparam int IA_W   = 8 * I_A_NUM_ASCII_CHARS;
  localparam int OA_W   = 8 * O_A_NUM_ASCII_CHARS;
  localparam int UB     = I_U_NUM_BITS;
  localparam int UIDX_W = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
  localparam int IIDX_W = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

  state_t state, state_nxt;
  op_t    op, op_nxt;

  logic [IA_W-1:0]   pend_name;
  logic [UB-1:0]     pend_pass;
  logic [UIDX_W-1:0] pend_uidx;

  logic [IA_W-1:0]      usr_name [MAX_USERS];
  logic [UB-1:0]        usr_pass [MAX_USERS];
  logic [1:0]           usr_perm [MAX_USERS];
  logic [MAX_USERS-1:0] usr_used;

  logic [IA_W-1:0]      itm_name  [MAX_ITEMS];
  logic [UIDX_W-1:0]    itm_owner [MAX_ITEMS];
  logic [UB-1:0]        itm_stock [MAX_ITEMS];
  logic [MAX_ITEMS-1:0] itm_used;

  logic              logged_in;
  logic [UIDX_W-1:0] sess_idx;
  logic [1:0]        sess_perm;

  logic              usr_hit, usr_full;
  logic [UIDX_W-1:0] usr_hit_idx, usr_free_idx;
  logic              itm_hit, itm_full;
  logic [IIDX_W-1:0] itm_hit_idx, itm_free_idx;

  logic is_login, is_logout, is_addusr, is_delusr, is_additem, is_delitem, is_buy;

  logic [STAT_W-1:0] msg;
  logic act_logout, act_login, act_latch_name, act_latch_pass, act_latch_uidx;
  logic act_add_user, act_del_user, act_add_item, act_del_item, act_buy;

  shop_cam_lookup #(.DEPTH(MAX_USERS), .KEY_W(IA_W), .IDX_W(UIDX_W)) u_usr_cam (
    .key      (bus.i_a),
    .keys     (usr_name),
    .used     (usr_used),
    .hit      (usr_hit),
    .hit_idx  (usr_hit_idx),
    .free_idx (usr_free_idx),
    .full     (usr_full)
  );

  shop_cam_lookup #(.DEPTH(MAX_ITEMS), .KEY_W(IA_W), .IDX_W(IIDX_W)) u_itm_cam (
    .key      (bus.i_a),
    .keys     (itm_name),
    .used     (itm_used),
    .hit      (itm_hit),
    .hit_idx  (itm_hit_idx),
    .free_idx (itm_free_idx),
    .full     (itm_full)
  );

  assign is_login   = (bus.i_a == IA_W'(KEY_LOGIN));
  assign is_logout  = (bus.i_a == IA_W'(KEY_LOGOUT));
  assign is_addusr  = (bus.i_a == IA_W'(KEY_ADDUSR));
  assign is_delusr  = (bus.i_a == IA_W'(KEY_DELUSR));
  assign is_additem = (bus.i_a == IA_W'(KEY_ADDITEM));
  assign is_delitem = (bus.i_a == IA_W'(KEY_DELITEM));
  assign is_buy     = (bus.i_a == IA_W'(KEY_BUY));

  // Perms are read live from the table. A logged-out session has none.
  assign sess_perm = logged_in ? usr_perm[sess_idx] : 2'b00;

  // Next state, response word and table actions for the current token.
  always_comb begin
    state_nxt      = state;
    op_nxt         = op;
    msg            = '0;
    act_logout     = 1'b0;
    act_login      = 1'b0;
    act_latch_name = 1'b0;
    act_latch_pass = 1'b0;
    act_latch_uidx = 1'b0;
    act_add_user   = 1'b0;
    act_del_user   = 1'b0;
    act_add_item   = 1'b0;
    act_del_item   = 1'b0;
    act_buy        = 1'b0;
    if (bus.i_rdy) begin
      state_nxt = ST_CMD;
      case (state)
        ST_CMD: begin
          if (is_login) begin
            op_nxt    = OP_LOGIN;
            state_nxt = ST_USRNAME;
            msg       = MSG_USRNAME;
          end else if (is_logout) begin
            if (logged_in) begin
              act_logout = 1'b1;
              msg        = MSG_LOGGEDOUT;
            end else begin
              msg = MSG_INVALPERM;
            end
          end else if (is_addusr || is_delusr) begin
            if (sess_perm[PERM_ADMIN]) begin
              op_nxt    = is_addusr ? OP_ADDUSR : OP_DELUSR;
              state_nxt = ST_USRNAME;
              msg       = MSG_USRNAME;
            end else begin
              msg = MSG_INVALPERM;
            end
          end else if (is_additem || is_delitem) begin
            if (sess_perm[PERM_SELLER]) begin
              op_nxt    = is_additem ? OP_ADDITEM : OP_DELITEM;
              state_nxt = ST_ITMNAME;
              msg       = MSG_ITMNAME;
            end else begin
              msg = MSG_INVALPERM;
            end
          end else if (is_buy) begin
            if (logged_in) begin
              op_nxt    = OP_BUY;
              state_nxt = ST_ITMNAME;
              msg       = MSG_ITMNAME;
            end else begin
              msg = MSG_INVALPERM;
            end
          end else begin
            msg = MSG_INVALCMD;
          end
        end
        ST_USRNAME: begin
          if (op == OP_LOGIN) begin
            if (usr_hit) begin
              act_latch_uidx = 1'b1;
              state_nxt      = ST_PASSWRD;
              msg            = MSG_PASSWRD;
            end else begin
              msg = MSG_USRUNKNWN;
            end
          end else if (op == OP_ADDUSR) begin
            if (usr_hit) begin
              msg = MSG_USRTAKEN;
            end else if (usr_full) begin
              msg = MSG_USRSFULL;
            end else begin
              act_latch_name = 1'b1;
              state_nxt      = ST_PASSWRD;
              msg            = MSG_PASSWRD;
            end
          end else begin
            if (usr_hit && (usr_hit_idx == '0)) begin
              msg = MSG_NODELADMN;
            end else if (!usr_hit) begin
              msg = MSG_USRUNKNWN;
            end else begin
              act_del_user = 1'b1;
              msg          = MSG_USRDELETD;
            end
          end
        end
        ST_PASSWRD: begin
          if (op == OP_ADDUSR) begin
            act_latch_pass = 1'b1;
            state_nxt      = ST_PERMS;
            msg            = MSG_PERMS;
          end else if (bus.i_u == usr_pass[pend_uidx]) begin
            act_login = 1'b1;
            msg       = MSG_LOGGEDIN;
          end else begin
            msg = MSG_BADPASS;
          end
        end
        ST_PERMS: begin
          act_add_user = 1'b1;
          msg          = MSG_USRADDED;
        end
        ST_ITMNAME: begin
          if (op == OP_ADDITEM) begin
            if (itm_hit) begin
              msg = MSG_ITMEXISTS;
            end else if (itm_full) begin
              msg = MSG_ITMSFULL;
            end else begin
              act_latch_name = 1'b1;
              state_nxt      = ST_ITMSTCK;
              msg            = MSG_STOCK;
            end
          end else if (!itm_hit) begin
            msg = MSG_ITMUNKNWN;
          end else if (op == OP_DELITEM) begin
            if ((itm_owner[itm_hit_idx] != sess_idx) && !sess_perm[PERM_ADMIN]) begin
              msg = MSG_NTYOURITM;
            end else begin
              act_del_item = 1'b1;
              msg          = MSG_ITMDELETD;
            end
          end else begin
            if (itm_stock[itm_hit_idx] == '0) begin
              msg = MSG_NOSTOCK;
            end else begin
              act_buy = 1'b1;
              msg     = MSG_ITMBOUGHT;
            end
          end
        end
        ST_ITMSTCK: begin
          act_add_item = 1'b1;
          msg          = MSG_ITMADDED;
        end
        default: state_nxt = ST_CMD;
      endcase
    end
  end

  // FSM state, pending command and response word registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_CMD;
      op        <= OP_LOGIN;
      bus.o_a   <= OA_W'(MSG_CMD);
      bus.o_vld <= 1'b0;
    end else begin
      state     <= state_nxt;
      op        <= op_nxt;
      bus.o_vld <= bus.i_rdy;
      if (bus.i_rdy) begin
        bus.o_a <= OA_W'(msg);
      end
    end
  end

  // Tables, latched operands and session, updated on the response edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_name <= '0;
      pend_pass <= '0;
      pend_uidx <= '0;
      logged_in <= 1'b0;
      sess_idx  <= '0;
      for (int i = 0; i < MAX_USERS; i++) begin
        usr_name[i] <= '0;
        usr_pass[i] <= '0;
        usr_perm[i] <= '0;
      end
      usr_name[0] <= ADMIN_USERNAME;
      usr_pass[0] <= ADMIN_PASSWORD;
      usr_perm[0] <= 2'b11;
      usr_used    <= {{(MAX_USERS-1){1'b0}}, 1'b1};
      for (int i = 0; i < MAX_ITEMS; i++) begin
        itm_name[i]  <= '0;
        itm_owner[i] <= '0;
        itm_stock[i] <= '0;
      end
      itm_used <= '0;
    end else begin
      if (act_latch_name) pend_name <= bus.i_a;
      if (act_latch_pass) pend_pass <= bus.i_u;
      if (act_latch_uidx) pend_uidx <= usr_hit_idx;
      if (act_logout) logged_in <= 1'b0;
      if (act_login) begin
        logged_in <= 1'b1;
        sess_idx  <= pend_uidx;
      end
      if (act_add_user) begin
        usr_name[usr_free_idx] <= pend_name;
        usr_pass[usr_free_idx] <= pend_pass;
        usr_perm[usr_free_idx] <= bus.i_u[1:0];
        usr_used[usr_free_idx] <= 1'b1;
      end
      // Deleting a user also drops its items; deleting the session's own
      // slot ends the session so it cannot act with a freed slot's perms.
      if (act_del_user) begin
        usr_used[usr_hit_idx] <= 1'b0;
        for (int i = 0; i < MAX_ITEMS; i++) begin
          if (itm_used[i] && (itm_owner[i] == usr_hit_idx)) begin
            itm_used[i] <= 1'b0;
          end
        end
        if (logged_in && (sess_idx == usr_hit_idx)) logged_in <= 1'b0;
      end
      if (act_add_item) begin
        itm_name[itm_free_idx]  <= pend_name;
        itm_owner[itm_free_idx] <= sess_idx;
        itm_stock[itm_free_idx] <= bus.i_u;
        itm_used[itm_free_idx]  <= 1'b1;
      end
      if (act_del_item) itm_used[itm_hit_idx] <= 1'b0;
      if (act_buy) itm_stock[itm_hit_idx] <= itm_stock[itm_hit_idx] - 1'b1;
    end
  end

endmodule

// File: tb/tb_shop_ctrl.sv
// tb_shop_ctrl: self-checking bench for shop_ctrl with default parameters.
// A directed sequence walks the main commands with literal expected words.
// Randomized tokens and occasional resets follow. A command-level reference
// model predicts o_a/o_vld, and these are compared on every negative edge.
module tb_shop_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shop_if #(.IA_CHARS(7), .OA_CHARS(9), .U_BITS(4)) bus ();

  shop_ctrl dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  // Reference model: tables as plain arrays, command progress as name + step.
  logic [55:0] m_uname [5];
  logic [3:0]  m_upass [5];
  logic [1:0]  m_uperm [5];
  bit          m_uused [5];
  logic [55:0] m_iname [8];
  int          m_iowner[8];
  int          m_istock[8];
  bit          m_iused [8];
  bit          m_in;
  int          m_sess;
  string       m_cmd;
  int          m_step;
  logic [55:0] m_pname;
  logic [3:0]  m_ppass;
  int          m_puser;
  string       m_last = "Cmd?";
  logic        exp_vld = 1'b0;

  logic [55:0] pool [16];

  function automatic string vec2str(input logic [71:0] v);
    string s = "";
    for (int i = 8; i >= 0; i--) begin
      if (v[i*8 +: 8] != 8'h00) s = $sformatf("%s%c", s, v[i*8 +: 8]);
    end
    return s;
  endfunction

  function automatic string key_of(input logic [55:0] a);
    if (a == 56'("Login"))   return "Login";
    if (a == 56'("Logout"))  return "Logout";
    if (a == 56'("AddUsr"))  return "AddUsr";
    if (a == 56'("DelUsr"))  return "DelUsr";
    if (a == 56'("AddItem")) return "AddItem";
    if (a == 56'("DelItem")) return "DelItem";
    if (a == 56'("Buy"))     return "Buy";
    return "";
  endfunction

  function automatic bit allowed(input string c);
    if (c == "Login") return 1'b1;
    if (!m_in) return 1'b0;
    if (c == "AddUsr" || c == "DelUsr") return m_uperm[m_sess][1];
    if (c == "AddItem" || c == "DelItem") return m_uperm[m_sess][0];
    return 1'b1;
  endfunction

  function automatic int find_user(input logic [55:0] a);
    for (int i = 0; i < 5; i++) if (m_uused[i] && m_uname[i] == a) return i;
    return -1;
  endfunction

  function automatic int free_user();
    for (int i = 0; i < 5; i++) if (!m_uused[i]) return i;
    return -1;
  endfunction

  function automatic int find_item(input logic [55:0] a);
    for (int i = 0; i < 8; i++) if (m_iused[i] && m_iname[i] == a) return i;
    return -1;
  endfunction

  function automatic int free_item();
    for (int i = 0; i < 8; i++) if (!m_iused[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 5; i++) m_uused[i] = 1'b0;
    for (int i = 0; i < 8; i++) m_iused[i] = 1'b0;
    m_uname[0] = 56'("Adm");
    m_upass[0] = 4'd0;
    m_uperm[0] = 2'b11;
    m_uused[0] = 1'b1;
    m_in   = 1'b0;
    m_sess = 0;
    m_cmd  = "";
    m_step = 0;
    m_last = "Cmd?";
  endtask

  task automatic modelToken(input logic [55:0] a, input logic [3:0] u);
    string c;
    int k;
    int f;
    if (m_cmd == "") begin
      c = key_of(a);
      if (c == "") m_last = "InvalCmd";
      else if (!allowed(c)) m_last = "InvalPerm";
      else if (c == "Logout") begin
        m_in = 1'b0;
        m_last = "LoggedOut";
      end else begin
        m_cmd  = c;
        m_step = 1;
        m_last = (c == "Login" || c == "AddUsr" || c == "DelUsr") ? "Usrname?" : "ItmName?";
      end
      return;
    end
    c = m_cmd;
    m_cmd = "";
    if (c == "Login") begin
      if (m_step == 1) begin
        k = find_user(a);
        if (k < 0) m_last = "UsrUnknwn";
        else begin
          m_puser = k; m_last = "Passwrd?"; m_cmd = c; m_step = 2;
        end
      end else if (u == m_upass[m_puser]) begin
        m_in = 1'b1; m_sess = m_puser; m_last = "LoggedIn";
      end else m_last = "BadPass";
    end else if (c == "AddUsr") begin
      if (m_step == 1) begin
        if (find_user(a) >= 0) m_last = "UsrTaken";
        else if (free_user() < 0) m_last = "UsrsFull";
        else begin
          m_pname = a; m_last = "Passwrd?"; m_cmd = c; m_step = 2;
        end
      end else if (m_step == 2) begin
        m_ppass = u; m_last = "Perms?"; m_cmd = c; m_step = 3;
      end else begin
        f = free_user();
        m_uname[f] = m_pname; m_upass[f] = m_ppass; m_uperm[f] = u[1:0]; m_uused[f] = 1'b1;
        m_last = "UsrAdded";
      end
    end else if (c == "DelUsr") begin
      k = find_user(a);
      if (k == 0) m_last = "NoDelAdmn";
      else if (k < 0) m_last = "UsrUnknwn";
      else begin
        m_uused[k] = 1'b0;
        for (int i = 0; i < 8; i++) if (m_iowner[i] == k) m_iused[i] = 1'b0;
        if (m_in && m_sess == k) m_in = 1'b0;
        m_last = "UsrDeletd";
      end
    end else if (c == "AddItem") begin
      if (m_step == 1) begin
        if (find_item(a) >= 0) m_last = "ItmExists";
        else if (free_item() < 0) m_last = "ItmsFull";
        else begin
          m_pname = a; m_last = "Stock?"; m_cmd = c; m_step = 2;
        end
      end else begin
        f = free_item();
        m_iname[f] = m_pname; m_iowner[f] = m_sess; m_istock[f] = int'(u); m_iused[f] = 1'b1;
        m_last = "ItmAdded";
      end
    end else begin
      k = find_item(a);
      if (k < 0) m_last = "ItmUnknwn";
      else if (c == "DelItem") begin
        if (m_iowner[k] != m_sess && !m_uperm[m_sess][1]) m_last = "NtYourItm";
        else begin
          m_iused[k] = 1'b0; m_last = "ItmDeletd";
        end
      end else if (m_istock[k] == 0) m_last = "NoStock";
      else begin
        m_istock[k] = m_istock[k] - 1; m_last = "ItmBought";
      end
    end
  endtask

  task automatic checkOutput(input string name, input string exp_a, input logic exp_v);
    string got;
    got = vec2str(bus.o_a);
    n_checks++;
    if (!$isunknown(bus.o_a) && !$isunknown(bus.o_vld) && got == exp_a && bus.o_vld === exp_v)
      n_pass++;
    else
      $display("[TB] FAIL %s: o_a=\"%s\" o_vld=%b, expected o_a=\"%s\" o_vld=%b",
               name, got, bus.o_vld, exp_a, exp_v);
  endtask

  task automatic pinModel(input string name, input string exp_a);
    n_checks++;
    if (m_last == exp_a) n_pass++;
    else $display("[TB] FAIL %s_model: model=\"%s\" expected \"%s\"", name, m_last, exp_a);
  endtask

  // Presents one token for one cycle; returns just after the accepting edge.
  task automatic applyStimulus(input logic [55:0] a, input logic [3:0] u);
    bus.i_rdy = 1'b1;
    bus.i_a   = a;
    bus.i_u   = u;
    @(posedge clk);
    #1;
    bus.i_rdy = 1'b0;
  endtask

  task automatic tok(input string name, input logic [55:0] a, input logic [3:0] u,
                     input string exp_a);
    applyStimulus(a, u);
    checkOutput(name, exp_a, 1'b1);
    pinModel(name, exp_a);
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (reset) begin
      modelReset();
      exp_vld = 1'b0;
    end else begin
      exp_vld = bus.i_rdy;
      if (bus.i_rdy) modelToken(bus.i_a, bus.i_u);
    end
    started = 1'b1;
  end

  // Per-cycle comparison of DUT outputs with the model.
  always @(negedge clk) begin
    if (started) checkOutput("cycle", m_last, exp_vld);
  end

  initial begin
    pool[0]  = 56'("Login");   pool[1]  = 56'("Logout");
    pool[2]  = 56'("AddUsr");  pool[3]  = 56'("DelUsr");
    pool[4]  = 56'("AddItem"); pool[5]  = 56'("DelItem");
    pool[6]  = 56'("Buy");     pool[7]  = 56'("Adm");
    pool[8]  = 56'("Bob");     pool[9]  = 56'("Eve");
    pool[10] = 56'("Ann");     pool[11] = 56'("Joe");
    pool[12] = 56'("Pen");     pool[13] = 56'("Cup");
    pool[14] = 56'("Hat");     pool[15] = 56'("Xyz");

    reset     = 1'b1;
    bus.i_rdy = 1'b0;
    bus.i_a   = '0;
    bus.i_u   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_state", "Cmd?", 1'b0);

    tok("login_key",  56'("Login"), 4'd0, "Usrname?");
    tok("login_name", 56'("Adm"),   4'd0, "Passwrd?");
    tok("login_pass", 56'("Adm"),   4'd0, "LoggedIn");

    tok("addusr_key",   56'("AddUsr"), 4'd0, "Usrname?");
    tok("addusr_name",  56'("Bob"),    4'd0, "Passwrd?");
    tok("addusr_pass",  56'("Bob"),    4'd3, "Perms?");
    tok("addusr_perms", 56'("Bob"),    4'd1, "UsrAdded");
    tok("addusr2_key",  56'("AddUsr"), 4'd0, "Usrname?");
    tok("usr_taken",    56'("Bob"),    4'd0, "UsrTaken");

    tok("fill_eve_k", 56'("AddUsr"), 4'd0, "Usrname?");
    tok("fill_eve_n", 56'("Eve"),    4'd0, "Passwrd?");
    tok("fill_eve_p", 56'("Eve"),    4'd5, "Perms?");
    tok("fill_eve_r", 56'("Eve"),    4'd0, "UsrAdded");
    tok("fill_ann_k", 56'("AddUsr"), 4'd0, "Usrname?");
    tok("fill_ann_n", 56'("Ann"),    4'd0, "Passwrd?");
    tok("fill_ann_p", 56'("Ann"),    4'd5, "Perms?");
    tok("fill_ann_r", 56'("Ann"),    4'd0, "UsrAdded");
    tok("fill_joe_k", 56'("AddUsr"), 4'd0, "Usrname?");
    tok("fill_joe_n", 56'("Joe"),    4'd0, "Passwrd?");
    tok("fill_joe_p", 56'("Joe"),    4'd5, "Perms?");
    tok("fill_joe_r", 56'("Joe"),    4'd0, "UsrAdded");
    tok("full_key",   56'("AddUsr"), 4'd0, "Usrname?");
    tok("usrs_full",  56'("Hat"),    4'd0, "UsrsFull");
    tok("deladm_key", 56'("DelUsr"), 4'd0, "Usrname?");
    tok("no_del_adm", 56'("Adm"),    4'd0, "NoDelAdmn");

    tok("bob_login_k", 56'("Login"),   4'd0, "Usrname?");
    tok("bob_login_n", 56'("Bob"),     4'd0, "Passwrd?");
    tok("bob_login_p", 56'("Bob"),     4'd3, "LoggedIn");
    tok("additem_key", 56'("AddItem"), 4'd0, "ItmName?");
    tok("additem_nm",  56'("Pen"),     4'd0, "Stock?");
    tok("item_added",  56'("Pen"),     4'd1, "ItmAdded");
    tok("buy1_key",    56'("Buy"),     4'd0, "ItmName?");
    tok("buy1",        56'("Pen"),     4'd0, "ItmBought");
    tok("buy2_key",    56'("Buy"),     4'd0, "ItmName?");
    tok("no_stock",    56'("Pen"),     4'd0, "NoStock");

    tok("logout",       56'("Logout"),  4'd0, "LoggedOut");
    tok("inval_perm",   56'("AddItem"), 4'd0, "InvalPerm");
    tok("inval_cmd",    56'("Xyz"),     4'd0, "InvalCmd");
    tok("bad_login_k",  56'("Login"),   4'd0, "Usrname?");
    tok("bad_login_n",  56'("Adm"),     4'd0, "Passwrd?");
    tok("bad_pass",     56'("Adm"),     4'd5, "BadPass");

    tok("adm_login_k", 56'("Login"),  4'd0, "Usrname?");
    tok("adm_login_n", 56'("Adm"),    4'd0, "Passwrd?");
    tok("adm_login_p", 56'("Adm"),    4'd0, "LoggedIn");
    tok("delbob_key",  56'("DelUsr"), 4'd0, "Usrname?");
    tok("usr_deleted", 56'("Bob"),    4'd0, "UsrDeletd");
    tok("buy_gone_k",  56'("Buy"),    4'd0, "ItmName?");
    tok("item_gone",   56'("Pen"),    4'd0, "ItmUnknwn");

    tok("mid_add_key", 56'("AddItem"), 4'd0, "ItmName?");
    tok("mid_add_nm",  56'("Cup"),     4'd0, "Stock?");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_mid_cmd", "Cmd?", 1'b0);
    tok("post_rst_perm", 56'("AddItem"), 4'd0, "InvalPerm");
    tok("post_rst_cmd",  56'("Xyz"),     4'd0, "InvalCmd");
    tok("post_rst_eve",  56'("Login"),   4'd0, "Usrname?");
    tok("eve_gone",      56'("Eve"),     4'd0, "UsrUnknwn");
    tok("post_rst_lk",   56'("Login"),   4'd0, "Usrname?");
    tok("post_rst_ln",   56'("Adm"),     4'd0, "Passwrd?");
    tok("post_rst_lp",   56'("Adm"),     4'd0, "LoggedIn");
    tok("post_rst_buyk", 56'("Buy"),     4'd0, "ItmName?");
    tok("items_empty",   56'("Cup"),     4'd0, "ItmUnknwn");

    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset     = ($urandom_range(0, 249) == 0);
      bus.i_rdy = ($urandom_range(0, 2) != 0);
      bus.i_a   = pool[$urandom_range(0, 15)];
      bus.i_u   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    bus.i_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shop_ctrl.md
# shop_ctrl

Parametrised command controller for the shop database. Consumes one ASCII or numeric token per `i_rdy` strobe, walks a command state machine, and maintains a user table (name, password, permissions) and an item table (name, owner, stock). It answers each token with a registered ASCII status word on `o_a`. It sits between the terminal/testbench token source and the display path, and succeeds the single-user, fixed-size shop controller.

## Interface
- `MAX_USERS`, 5: user slots, including admin in slot 0 (2..15).
- `MAX_ITEMS`, 8: item slots (1..16).
- `I_A_NUM_ASCII_CHARS`, 7: ASCII token width in chars. Must fit the longest command key and name.
- `O_A_NUM_ASCII_CHARS`, 9: status word width in chars.
- `I_U_NUM_BITS`, 4: numeric token width. Carries password, permissions and stock.
- `ADMIN_USERNAME`, "Adm"; `ADMIN_PASSWORD`, 4'd0: reset contents of slot 0.
- `i_clk`  in  1: clock.
- `i_reset`  in  1: reset. Synchronous, active-high, single clock domain.
- `i_rdy`  in  1: token strobe. `i_a`/`i_u` are sampled in any cycle where it is high.
- `i_a`  in  8·I_A_NUM_ASCII_CHARS: ASCII token, right-aligned, zero-padded.
- `i_u`  in  I_U_NUM_BITS: numeric token.
- `o_a`  out  8·O_A_NUM_ASCII_CHARS: status/prompt word, right-aligned.
- `o_vld`  out  1: one-cycle pulse when `o_a` is updated.

## Operation
- **Reset state:**
  - State CMD, logged out.
  - Slot 0 = {ADMIN_USERNAME, ADMIN_PASSWORD, perms 2'b11}; all other user slots are free.
  - All item slots are free.
  - `o_a`="Cmd?", `o_vld`=0.
- **Permissions:** `i_u[1:0]`. Bit0 = seller (AddItem/DelItem). Bit1 = admin (AddUsr/DelUsr). Buy needs any logged-in user.
- **States:** CMD, USRNAME, PASSWRD, PERMS, ITMNAME, ITMSTCK. Only strobed tokens advance the FSM. In CMD, `i_a` is decoded as a command key:
  - Not a key: "InvalCmd", stay in CMD.
  - Key without permission: "InvalPerm", stay in CMD. Logged out, only Login is permitted.
  - Logout: clear the session, "LoggedOut", CMD.
  - Login/AddUsr/DelUsr: "Usrname?", go to USRNAME.
  - AddItem/DelItem/Buy: "ItmName?", go to ITMNAME.
- **USRNAME** (`i_a`):
  - Login, name known: "Passwrd?", PASSWRD.
  - Login, name unknown: "UsrUnknwn", CMD.
  - AddUsr, name taken: "UsrTaken", CMD.
  - AddUsr, table full: "UsrsFull", CMD.
  - AddUsr, otherwise: latch name, "Passwrd?", PASSWRD.
  - DelUsr, slot 0: "NoDelAdmn", CMD.
  - DelUsr, name unknown: "UsrUnknwn", CMD.
  - DelUsr, otherwise: free the slot and every item it owns, "UsrDeletd", CMD.
- **PASSWRD** (`i_u`):
  - Login, password matches: the session becomes that slot (replaces any prior session), "LoggedIn".
  - Login, mismatch: "BadPass".
  - AddUsr: latch the password, "Perms?", PERMS.
  - Every path except AddUsr returns to CMD.
- **PERMS** (`i_u`): write the user into the lowest free slot, "UsrAdded", CMD.
- **ITMNAME** (`i_a`):
  - AddItem, name exists: "ItmExists", CMD.
  - AddItem, table full: "ItmsFull", CMD.
  - AddItem, otherwise: "Stock?", ITMSTCK.
  - DelItem/Buy, name unknown: "ItmUnknwn", CMD.
  - DelItem, owned by another user and the session is not admin: "NtYourItm", CMD.
  - DelItem, otherwise: free the slot, "ItmDeletd", CMD.
  - Buy, stock 0: "NoStock", CMD.
  - Buy, otherwise: stock−1, "ItmBought", CMD.
- **ITMSTCK** (`i_u`):
  - Write {name, owner = session, stock} into the lowest free slot. Stock 0 is legal.
  - "ItmAdded", CMD.
- **Sizing:**
  - Name compare is on the full `i_a` width.
  - Stock is I_U_NUM_BITS wide, unsigned, with no wrap: decrement only when stock is nonzero.
  - The session index is `$clog2(MAX_USERS)` bits plus a logged-in flag.

## Timing
- Each accepted token updates `o_a` and pulses `o_vld` exactly 1 cycle later.
- Tables and state update on the same edge as `o_a`.
- Back-to-back strobes are legal. Each token sees the table state left by the previous token.
- Reset has priority over `i_rdy`.
- Reset mid-command discards the partial command and restores all reset contents on the next edge. `o_vld`=0 during reset.
- `o_a` holds its value between responses.

## Structure
- `shop_pkg`: state enum, command-key constants, status-word constants, perm bit positions.
- Sub-module `shop_cam_lookup` (parameters DEPTH, KEY_W):
  - Combinational name match producing hit and index.
  - Also produces lowest-free index and a full flag.
  - Instantiated for the user table and the item table.

## Test plan
- Reset; Login, "Adm", 0 → "Usrname?", "Passwrd?", "LoggedIn", each 1 cycle after its strobe.
- As admin: AddUsr, "Bob", 3, 1 → "UsrAdded". Then AddUsr, "Bob" → "UsrTaken".
- Add users until the table is full → "UsrsFull". DelUsr, "Adm" → "NoDelAdmn".
- As Bob: AddItem, "Pen", 1 → "ItmAdded". Buy "Pen" → "ItmBought". Buy "Pen" again → "NoStock".
- Logged out, AddItem → "InvalPerm". Garbage token "Xyz" → "InvalCmd". Login with a wrong password → "BadPass".
- Bob owns "Pen"; admin DelUsr "Bob" → "UsrDeletd", then Buy "Pen" → "ItmUnknwn". Reset asserted mid-AddItem → state CMD, items empty.
